// File: rtl/fetch_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_ctrl_if
// Brief   : Instruction-memory port between the fetch stage and the IMEM.
// Revision: 1.0
// ============================================================================
interface fetch_stage_ctrl_if;
    logic [31:0] imem_pc_o;
    logic        imem_enable_o;
    logic [31:0] imem_instruction_i;

    modport master (
        output imem_pc_o,
        output imem_enable_o,
        input  imem_instruction_i
    );

    modport slave (
        input  imem_pc_o,
        input  imem_enable_o,
        output imem_instruction_i
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_ctrl
// Brief   : IF control: PC, gated IMEM enable, response pairing, faults, count.
// Revision: 1.0
// ============================================================================
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 100,
    parameter int          CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_i,
    input  logic                 redirect_valid_i,
    input  logic [31:0]          redirect_pc_i,
    fetch_stage_ctrl_if.master   imem,
    output logic                 if_valid_o,
    output logic [31:0]          if_pc_o,
    output logic [31:0]          if_instruction_o,
    output logic                 fetch_fault_o,
    output logic [CNT_W-1:0]     fetch_count_o
);

    localparam logic [0:0]  S_RUN     = 1'b0;
    localparam logic [0:0]  S_FAULT   = 1'b1;
    localparam logic [31:0] C_LAST_PC = 32'(IMEM_BYTES - 4);

    logic [0:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_resp_pc;
    logic             r_valid;
    logic             r_fault;
    logic [CNT_W-1:0] r_count;

    logic w_run;
    logic w_in_range;
    logic w_enable;

    assign w_run      = (r_state == S_RUN);
    assign w_in_range = (r_pc <= C_LAST_PC);
    assign w_enable   = w_run & ~reset & ~stall_i & ~redirect_valid_i & w_in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_PC;
            r_resp_pc <= 32'h0;
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (redirect_valid_i) begin
                        // Redirect wins over stall; a misaligned target is fatal.
                        r_valid <= 1'b0;
                        if (redirect_pc_i[1:0] != 2'b00) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= redirect_pc_i;
                        end
                    end else if (stall_i) begin
                        r_valid <= r_valid;
                    end else if (!w_in_range) begin
                        r_valid <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_resp_pc <= r_pc;
                        r_valid   <= 1'b1;
                        r_pc      <= r_pc + 32'd4;
                        if (r_count != {CNT_W{1'b1}}) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    // Only reset leaves FAULT.
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    assign imem.imem_pc_o     = r_pc;
    assign imem.imem_enable_o = w_enable;
    assign if_valid_o         = r_valid;
    assign if_pc_o            = r_resp_pc;
    assign if_instruction_o   = imem.imem_instruction_i;
    assign fetch_fault_o      = r_fault;
    assign fetch_count_o      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage_ctrl
// Brief   : Scoreboard bench for fetch_stage_ctrl with an IMEM model.
// Revision: 1.0
// ============================================================================
module tb_fetch_stage_ctrl;

    localparam int          IMEM_BYTES = 100;
    localparam int          WORDS      = IMEM_BYTES / 4;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam longint      MAXC32     = 64'hFFFF_FFFF;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'h0;

    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instruction_o;
    logic        fetch_fault_o;
    logic [31:0] fetch_count_o;

    logic        b_valid, b_fault;
    logic [31:0] b_pc, b_instr;
    logic [3:0]  b_count;

    logic [31:0] r_rdata;
    logic [31:0] mem [WORDS];

    fetch_stage_ctrl_if ifs ();
    fetch_stage_ctrl_if ifs_b ();

    fetch_stage_ctrl #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES), .CNT_W(32)) dut (
        .clk(clk), .reset(rst), .stall_i(stall), .redirect_valid_i(redir),
        .redirect_pc_i(rpc), .imem(ifs), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
        .if_instruction_o(if_instruction_o), .fetch_fault_o(fetch_fault_o),
        .fetch_count_o(fetch_count_o)
    );

    // Narrow-counter copy, used only to observe counter saturation.
    fetch_stage_ctrl #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst), .stall_i(stall), .redirect_valid_i(redir),
        .redirect_pc_i(rpc), .imem(ifs_b), .if_valid_o(b_valid), .if_pc_o(b_pc),
        .if_instruction_o(b_instr), .fetch_fault_o(b_fault), .fetch_count_o(b_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] idx;
        idx = pc >> 2;
        return (idx < WORDS) ? mem[idx] : 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        if (rst) r_rdata <= NOP;
        else if (ifs.imem_enable_o) r_rdata <= mem_word(ifs.imem_pc_o);
    end
    assign ifs.imem_instruction_i   = r_rdata;
    assign ifs_b.imem_instruction_i = r_rdata;

    // Reference model state: what the stage should hold during the current cycle.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
    item_t       sb[$];
    logic [31:0] m_pc    = RESET_PC;
    logic        m_fault = 1'b0;
    logic        m_valid = 1'b0;
    longint      m_count = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_in_range(input logic [31:0] pc);
        return (longint'(pc) + 3) <= longint'(IMEM_BYTES - 1);
    endfunction

    // Model: advance by the rules, pushing each fetch's expected response.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            m_pc = RESET_PC; m_fault = 1'b0; m_count = 0; m_valid = 1'b0;
            sb.delete();
        end else if (m_fault) begin
            m_valid = 1'b0;
        end else if (redir) begin
            m_valid = 1'b0;
            if (rpc % 4 == 0) m_pc = rpc;
            else m_fault = 1'b1;
        end else if (stall) begin
            m_valid = m_valid;
        end else if (!model_in_range(m_pc)) begin
            m_valid = 1'b0;
            m_fault = 1'b1;
        end else begin
            sb.push_back('{pc: m_pc, instr: mem_word(m_pc)});
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_count < MAXC32) m_count++;
        end
    end

    // Monitor: per-cycle control checks, pop on each new presentation.
    item_t cur;
    logic  have_cur = 1'b0;
    logic  p_valid  = 1'b0;
    logic  p_stall  = 1'b0;
    always @(negedge clk) begin
        logic m_en;
        m_en = !rst && !m_fault && !stall && !redir && model_in_range(m_pc);
        chk("imem_enable", {31'b0, ifs.imem_enable_o}, {31'b0, m_en});
        chk("imem_pc", ifs.imem_pc_o, m_pc);
        chk("if_valid", {31'b0, if_valid_o}, {31'b0, m_valid});
        chk("fetch_fault", {31'b0, fetch_fault_o}, {31'b0, m_fault});
        chk("fetch_count", fetch_count_o, m_count[31:0]);
        chk("count_sat4", {28'b0, b_count}, (m_count > 15) ? 32'd15 : m_count[31:0]);
        if (if_valid_o) begin
            if (!p_valid || !p_stall) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    have_cur = 1'b0;
                    $display("FAIL sb_underflow: got presentation pc %h expected none", if_pc_o);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (have_cur) begin
                chk("if_pc", if_pc_o, cur.pc);
                chk("if_instruction", if_instruction_o, cur.instr);
            end
        end
        p_valid = if_valid_o;
        p_stall = stall;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'h4040_02B7;
        mem[1]  = 32'h4000_0337;
        mem[2]  = 32'hF002_8053;
        mem[3]  = 32'hF003_00D3;
        mem[16] = 32'h0070_0613;
        mem[17] = 32'hD006_74D3;

        step(3);
        @(negedge clk);
        chk("rst_if_pc", if_pc_o, 32'h0);
        chk("rst_if_instr", if_instruction_o, NOP);
        step(1);
        rst = 1'b0;

        // Stream, then stall three cycles while pc 8 is presented.
        step(3);
        stall = 1'b1;
        @(negedge clk);
        chk("tp_pc8", if_pc_o, 32'h8);
        chk("tp_instr8", if_instruction_o, 32'hF002_8053);
        step(3);
        stall = 1'b0;
        step(1);
        @(negedge clk);
        chk("tp_pc12", if_pc_o, 32'hC);
        chk("tp_instr12", if_instruction_o, 32'hF003_00D3);

        // Redirect to 0x40 with a simultaneous stall while presenting pc 4.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        stall = 1'b1; redir = 1'b1; rpc = 32'h40;
        step(1);
        stall = 1'b0; redir = 1'b0;
        step(1);
        @(negedge clk);
        chk("tp_pc40", if_pc_o, 32'h40);
        chk("tp_instr40", if_instruction_o, 32'h0070_0613);
        step(1);
        @(negedge clk);
        chk("tp_pc44", if_pc_o, 32'h44);

        // Misaligned redirect is fatal; a later redirect is ignored.
        redir = 1'b1; rpc = 32'h42;
        step(1);
        redir = 1'b0;
        step(2);
        redir = 1'b1; rpc = 32'h0;
        step(1);
        redir = 1'b0;
        step(2);
        @(negedge clk);
        chk("tp_misalign_fault", {31'b0, fetch_fault_o}, 32'h1);

        // Run off the end of memory.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(30);
        @(negedge clk);
        chk("tp_bounds_count", fetch_count_o, 32'd25);
        chk("tp_bounds_fault", {31'b0, fetch_fault_o}, 32'h1);

        // Reset during a stall at pc 20.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(6);
        stall = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("tp_rst_count", fetch_count_o, 32'd0);
        chk("tp_rst_pc", ifs.imem_pc_o, 32'h0);
        step(4);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst   = m_fault ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 99) < 25);
            redir = ($urandom_range(0, 99) < 6);
            rpc   = 32'($urandom_range(0, 27)) * 32'd4;
            if ($urandom_range(0, 9) == 0) rpc = rpc + 32'($urandom_range(1, 3));
            step(1);
        end
        rst = 1'b0; stall = 1'b0; redir = 1'b0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
